// File: rtl/joy_poll_sched_if.sv
// rtl/joy_poll_sched_if.sv - request/response bundle between the poll scheduler and the shared SPI master
interface joy_poll_sched_if;
    logic        spi_req;
    logic        spi_sel;
    logic        spi_done;
    logic [39:0] spi_data;

    // Scheduler side: raises requests, receives completion and data.
    modport master (
        output spi_req,
        output spi_sel,
        input  spi_done,
        input  spi_data
    );

    // SPI master side.
    modport slave (
        input  spi_req,
        input  spi_sel,
        output spi_done,
        output spi_data
    );
endinterface

// File: rtl/joy_poll_sched.sv
// rtl/joy_poll_sched.sv - joystick poll scheduler and shared-SPI arbiter; second joystick enabled by JOY2_EN
module joy_poll_sched #(
    parameter int unsigned POLL_DIV = 2500000,
    parameter int unsigned GAP_CYC  = 1000,
    parameter int unsigned TIMEOUT  = 100000
) (
    input  logic                    clk,
    input  logic                    clr,
    joy_poll_sched_if.master        spi,
    output logic [9:0]              joy1_x,
    output logic [9:0]              joy1_y,
    output logic [9:0]              joy2_x,
    output logic [9:0]              joy2_y,
    output logic [2:0]              btn1,
    output logic [2:0]              btn2,
    output logic [1:0]              joy_err,
    output logic                    clk_cursor,
    output logic                    prev_clk_cursor
);

    localparam logic [23:0] POLL_LAST = 24'(POLL_DIV - 1);
    localparam logic [23:0] TMO_LOAD  = 24'(TIMEOUT - 1);
    localparam logic [9:0]  AXIS_MID  = 10'd512;
`ifdef JOY2_EN
    localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ1,
        ST_WAIT1,
`ifdef JOY2_EN
        ST_GAP,
        ST_REQ2,
        ST_WAIT2,
`endif
        ST_PUB
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] period_cnt;
    logic [23:0] tmo_cnt;
    logic        period_wrap;
    logic        poll_due;
    logic        tmo_hit;
    logic        req_q;
    logic        err1_q;
    logic        consume;
    logic        req_set;
    logic        req_drop;
    logic        lat1;
    logic        err1_set;
    logic        pub;
    logic [9:0]  rx_x;
    logic [9:0]  rx_y;
    logic [2:0]  rx_btn;
    logic        unused_data;
`ifdef JOY2_EN
    logic [23:0] gap_cnt;
    logic        gap_load;
    logic        lat2;
    logic        err2_set;
    logic        sel_q;
    logic        err2_q;
`else
    logic [31:0] unused_gap;
`endif

    // Byte layout of a PmodJSTK reply: low byte first, then the two high bits.
    assign rx_x        = {spi.spi_data[25:24], spi.spi_data[39:32]};
    assign rx_y        = {spi.spi_data[9:8], spi.spi_data[23:16]};
    assign rx_btn      = spi.spi_data[2:0];
    assign unused_data = ^{spi.spi_data[31:26], spi.spi_data[15:10], spi.spi_data[7:3]};

    assign period_wrap = (period_cnt == POLL_LAST);
    assign tmo_hit     = (tmo_cnt == 24'd0);
    assign spi.spi_req = req_q;

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state action strobes; spi_done outside the wait states is ignored
    always_comb begin
        state_nxt = state;
        consume   = 1'b0;
        req_set   = 1'b0;
        req_drop  = 1'b0;
        lat1      = 1'b0;
        err1_set  = 1'b0;
        pub       = 1'b0;
`ifdef JOY2_EN
        gap_load  = 1'b0;
        lat2      = 1'b0;
        err2_set  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (poll_due) begin
                    consume   = 1'b1;
                    state_nxt = ST_REQ1;
                end
            end
            ST_REQ1: begin
                req_set   = 1'b1;
                state_nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
                // A done arriving on the timeout cycle still counts as a good sample.
                if (spi.spi_done || tmo_hit) begin
                    req_drop = 1'b1;
                    lat1     = spi.spi_done;
                    err1_set = !spi.spi_done;
`ifdef JOY2_EN
                    gap_load  = 1'b1;
                    state_nxt = ST_GAP;
`else
                    state_nxt = ST_PUB;
`endif
                end
            end
`ifdef JOY2_EN
            ST_GAP: begin
                if (gap_cnt == 24'd0) begin
                    state_nxt = ST_REQ2;
                end
            end
            ST_REQ2: begin
                req_set   = 1'b1;
                state_nxt = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (spi.spi_done || tmo_hit) begin
                    req_drop  = 1'b1;
                    lat2      = spi.spi_done;
                    err2_set  = !spi.spi_done;
                    state_nxt = ST_PUB;
                end
            end
`endif
            ST_PUB: begin
                pub       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Free-running period counter; poll_due holds a single pending poll, extra wraps fold into it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            period_cnt <= 24'd0;
            poll_due   <= 1'b0;
        end else begin
            period_cnt <= period_wrap ? 24'd0 : period_cnt + 24'd1;
            if (period_wrap) begin
                poll_due <= 1'b1;
            end else if (consume) begin
                poll_due <= 1'b0;
            end
        end
    end

    // Request level and timeout countdown, reloaded each time a request is raised
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            req_q   <= 1'b0;
            tmo_cnt <= 24'd0;
        end else if (req_set) begin
            req_q   <= 1'b1;
            tmo_cnt <= TMO_LOAD;
        end else begin
            if (req_drop) begin
                req_q <= 1'b0;
            end
            if (!tmo_hit) begin
                tmo_cnt <= tmo_cnt - 24'd1;
            end
        end
    end

    // Joystick 1 sample registers and sticky timeout flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            joy1_x <= AXIS_MID;
            joy1_y <= AXIS_MID;
            btn1   <= 3'd0;
            err1_q <= 1'b0;
        end else begin
            if (lat1) begin
                joy1_x <= rx_x;
                joy1_y <= rx_y;
                btn1   <= rx_btn;
            end
            if (err1_set) begin
                err1_q <= 1'b1;
            end
        end
    end

    // Publish strobe and its one-cycle delayed copy for the downstream edge pair
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_cursor      <= 1'b0;
            prev_clk_cursor <= 1'b0;
        end else begin
            clk_cursor      <= pub;
            prev_clk_cursor <= clk_cursor;
        end
    end

`ifdef JOY2_EN
    // Inter-transaction gap countdown
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gap_cnt <= 24'd0;
        end else if (gap_load) begin
            gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != 24'd0) begin
            gap_cnt <= gap_cnt - 24'd1;
        end
    end

    // Target select, only changed when a request is raised so it is stable while spi_req is high
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_q <= 1'b0;
        end else if (req_set) begin
            sel_q <= (state == ST_REQ2);
        end
    end

    // Joystick 2 sample registers and sticky timeout flag
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            joy2_x <= AXIS_MID;
            joy2_y <= AXIS_MID;
            btn2   <= 3'd0;
            err2_q <= 1'b0;
        end else begin
            if (lat2) begin
                joy2_x <= rx_x;
                joy2_y <= rx_y;
                btn2   <= rx_btn;
            end
            if (err2_set) begin
                err2_q <= 1'b1;
            end
        end
    end

    assign spi.spi_sel = sel_q;
    assign joy_err     = {err2_q, err1_q};
`else
    // Single-joystick build: second player sits centred with no buttons and no errors.
    assign spi.spi_sel = 1'b0;
    assign joy2_x      = AXIS_MID;
    assign joy2_y      = AXIS_MID;
    assign btn2        = 3'd0;
    assign joy_err     = {1'b0, err1_q};
    assign unused_gap  = GAP_CYC;
`endif

endmodule

// File: tb/tb_joy_poll_sched.sv
// tb/tb_joy_poll_sched.sv - self-checking bench for joy_poll_sched
module tb_joy_poll_sched;
    localparam int POLL_DIV = 100;
    localparam int GAP_CYC  = 4;
    localparam int TIMEOUT  = 50;
`ifdef JOY2_EN
    localparam logic [1:0] ERR_BOTH = 2'b11;
`else
    localparam logic [1:0] ERR_BOTH = 2'b01;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic [9:0] joy1_x, joy1_y, joy2_x, joy2_y;
    logic [2:0] btn1, btn2;
    logic [1:0] joy_err;
    logic       clk_cursor, prev_clk_cursor;

    joy_poll_sched_if spi_bus ();

    joy_poll_sched #(
        .POLL_DIV(POLL_DIV),
        .GAP_CYC (GAP_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .clr            (clr),
        .spi            (spi_bus),
        .joy1_x         (joy1_x),
        .joy1_y         (joy1_y),
        .joy2_x         (joy2_x),
        .joy2_y         (joy2_y),
        .btn1           (btn1),
        .btn2           (btn2),
        .joy_err        (joy_err),
        .clk_cursor     (clk_cursor),
        .prev_clk_cursor(prev_clk_cursor)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         d1;
        logic [9:0] x1, y1;
        logic [2:0] b1;
        int         d2;
        logic [9:0] x2, y2;
        logic [2:0] b2;
        logic [1:0] exp_err;
    } vec_t;

    typedef struct {
        logic [9:0] x1, y1;
        logic [2:0] b1;
        logic [9:0] x2, y2;
        logic [2:0] b2;
    } samp_t;

    vec_t  vecs[6];
    samp_t sb[$];
    samp_t model;
    int    errors = 0;
    int    checks = 0;
    int    c0, t_idle, k_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic abort(input string name);
        errors++;
        checks++;
        $display("FAIL %s: bounded wait expired at cycle %0d", name, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "stopped");
    endtask

    function automatic logic [39:0] pack(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        return {x[7:0], 6'b101101, x[9:8], y[7:0], 6'b010011, y[9:8], 5'b11001, b};
    endfunction

    task automatic reset_model();
        model = '{x1: 10'd512, y1: 10'd512, b1: 3'd0, x2: 10'd512, y2: 10'd512, b2: 3'd0};
        c0     = cyc;
        t_idle = cyc;
        k_prev = cyc;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, spi_bus.spi_req, 1'b0);
        chk({tag, "_sel"}, spi_bus.spi_sel, 1'b0);
        chk({tag, "_j1x"}, joy1_x, 10'd512);
        chk({tag, "_j1y"}, joy1_y, 10'd512);
        chk({tag, "_j2x"}, joy2_x, 10'd512);
        chk({tag, "_j2y"}, joy2_y, 10'd512);
        chk({tag, "_btn"}, {btn1, btn2}, 6'd0);
        chk({tag, "_err"}, joy_err, 2'b00);
        chk({tag, "_cur"}, {clk_cursor, prev_clk_cursor}, 2'b00);
    endtask

    task automatic wait_req(input string name, output int t);
        t = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (spi_bus.spi_req === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) abort(name);
    endtask

    // Answer (or ignore) one request; t_exit is the edge where the DUT leaves the wait state.
    task automatic serve(input string name, input int idx, input int d, input logic [9:0] x,
                         input logic [9:0] y, input logic [2:0] b, input int t_req, output int t_exit);
        t_exit = -1;
        if (d >= 1 && d <= TIMEOUT) begin
            repeat (d - 1) @(negedge clk);
            chk({name, "_req_held"}, spi_bus.spi_req, 1'b1);
            spi_bus.spi_done = 1'b1;
            spi_bus.spi_data = pack(x, y, b);
            @(negedge clk);
            spi_bus.spi_done = 1'b0;
            spi_bus.spi_data = 40'd0;
            t_exit = cyc;
            chk({name, "_req_drop"}, spi_bus.spi_req, 1'b0);
            if (idx == 0) begin
                model.x1 = x; model.y1 = y; model.b1 = b;
            end else begin
                model.x2 = x; model.y2 = y; model.b2 = b;
            end
        end else begin
            for (int n = 0; n < TIMEOUT + 10; n++) begin
                @(negedge clk);
                if (spi_bus.spi_req === 1'b0) begin
                    t_exit = cyc;
                    break;
                end
            end
            if (t_exit < 0) abort({name, "_tmo_wait"});
            chk({name, "_tmo_len"}, t_exit - t_req, TIMEOUT);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        samp_t e;
        string nm;
        int    w, exp_req, t_req, t_exit, t_pub;
        v  = vecs[i];
        nm = $sformatf("v%0d", i);
        // Poll due at the first wrap not already consumed; consumed one edge after IDLE sees it.
        w = c0 + POLL_DIV;
        while (w < k_prev) w += POLL_DIV;
        exp_req = ((t_idle > w) ? t_idle : w) + 2;
        k_prev  = exp_req - 1;
        wait_req({nm, "_req1"}, t_req);
        chk({nm, "_start"}, t_req, exp_req);
        chk({nm, "_sel1"}, spi_bus.spi_sel, 1'b0);
        serve({nm, "_j1"}, 0, v.d1, v.x1, v.y1, v.b1, t_req, t_exit);
`ifdef JOY2_EN
        wait_req({nm, "_req2"}, t_req);
        chk({nm, "_gap"}, t_req - t_exit, GAP_CYC + 1);
        chk({nm, "_sel2"}, spi_bus.spi_sel, 1'b1);
        serve({nm, "_j2"}, 1, v.d2, v.x2, v.y2, v.b2, t_req, t_exit);
`endif
        sb.push_back(model);
        t_pub = -1;
        for (int n = 0; n < 10; n++) begin
            if (clk_cursor === 1'b1) begin
                t_pub = cyc;
                break;
            end
            @(negedge clk);
            chk({nm, "_sel_pre"}, spi_bus.spi_sel & ~spi_bus.spi_req, 1'b0);
        end
        if (t_pub < 0) abort({nm, "_pub_wait"});
        chk({nm, "_pub_lat"}, t_pub - t_exit, 1);
        chk({nm, "_prev0"}, prev_clk_cursor, 1'b0);
        e = sb.pop_front();
        chk({nm, "_j1x"}, joy1_x, e.x1);
        chk({nm, "_j1y"}, joy1_y, e.y1);
        chk({nm, "_btn1"}, btn1, e.b1);
        chk({nm, "_j2x"}, joy2_x, e.x2);
        chk({nm, "_j2y"}, joy2_y, e.y2);
        chk({nm, "_btn2"}, btn2, e.b2);
        chk({nm, "_err"}, joy_err, v.exp_err);
        @(negedge clk);
        chk({nm, "_cur_fall"}, clk_cursor, 1'b0);
        chk({nm, "_prev1"}, prev_clk_cursor, 1'b1);
        t_idle = t_pub;
    endtask

    initial begin
        #400000;
        abort("watchdog");
    end

    initial begin
        int t_req, t_exit;
        vecs[0] = '{d1: 10, x1: 10'd100, y1: 10'd900, b1: 3'b010,
                    d2: 10, x2: 10'd700, y2: 10'd300, b2: 3'b101, exp_err: 2'b00};
        vecs[1] = '{d1: 0, x1: 10'd5, y1: 10'd6, b1: 3'b111,
                    d2: 10, x2: 10'd1023, y2: 10'd0, b2: 3'b111, exp_err: 2'b01};
        vecs[2] = '{d1: TIMEOUT, x1: 10'd0, y1: 10'd1023, b1: 3'b001,
                    d2: TIMEOUT, x2: 10'd512, y2: 10'd1, b2: 3'b100, exp_err: 2'b01};
        vecs[3] = '{d1: 0, x1: 10'd0, y1: 10'd0, b1: 3'b000,
                    d2: 0, x2: 10'd0, y2: 10'd0, b2: 3'b000, exp_err: ERR_BOTH};
        vecs[4] = vecs[3];
        vecs[5] = '{d1: 1, x1: 10'd333, y1: 10'd666, b1: 3'b110,
                    d2: 1, x2: 10'd42, y2: 10'd999, b2: 3'b011, exp_err: ERR_BOTH};

        clr = 1'b1;
        spi_bus.spi_done = 1'b0;
        spi_bus.spi_data = 40'd0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        clr = 1'b0;
        reset_model();

        run_vec(0);

        // A done pulse while idle must not disturb the samples.
        spi_bus.spi_done = 1'b1;
        spi_bus.spi_data = pack(10'd1, 10'd2, 3'b011);
        @(negedge clk);
        spi_bus.spi_done = 1'b0;
        @(negedge clk);
        chk("stray_j1x", joy1_x, model.x1);
        chk("stray_j2y", joy2_y, model.y2);
        chk("stray_err", joy_err, 2'b00);

        // Reset while a request is outstanding in the last wait state of a round.
        wait_req("mid_req1", t_req);
`ifdef JOY2_EN
        serve("mid_j1", 0, 3, 10'd11, 10'd22, 3'b001, t_req, t_exit);
        wait_req("mid_req2", t_req);
`endif
        repeat (5) @(negedge clk);
        clr = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        clr = 1'b0;
        reset_model();

        for (int i = 1; i < 6; i++) run_vec(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
